snake_move_scheduler: RTL and testbench
=======================================

# snake_move_scheduler

Sequences the snake game from the debounced, edge-detected events produced by the input handler. Holds the game-state machine (idle/running/paused/over). Buffers direction presses in a small FIFO, dropping illegal ones. Releases at most one direction change per game tick to the movement datapath, so fast double presses such as up-then-left within one tick are applied on consecutive steps instead of being lost or causing a reversal.

## Interface
- QDEPTH, 4, direction FIFO depth; power of two, 2..16
- INIT_DIR, 2'b11, direction loaded at reset/restart; encoding 00 up, 01 down, 10 left, 11 right
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- direction_in  in  2  direction code from input handler
- direction_valid_in  in  1  one-cycle pulse, direction_in valid
- start_pause_event_in  in  1  one-cycle start/pause pulse
- reset_event_in  in  1  one-cycle soft-reset pulse
- tick_in  in  1  one-cycle game-step tick from tick generator
- collision_in  in  1  level from collision checker, sampled only in RUNNING
- game_state_out  out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 OVER
- cur_dir_out  out  2  direction the snake moves on the current step
- step_pulse_out  out  1  one-cycle pulse: advance snake one cell using cur_dir_out
- clear_pulse_out  out  1  one-cycle pulse: board/score must reinitialise
- drop_pulse_out  out  1  one-cycle pulse: a direction event was discarded
- queue_count_out  out  $clog2(QDEPTH+1)  FIFO occupancy

## Operation
- Reset: state IDLE, cur_dir_out=INIT_DIR, FIFO empty, count 0, all pulse outputs 0.
- Reversal test: two codes are opposite when bit[1] is equal and bit[0] differs.
- State machine, evaluated with priority reset > reset_event_in > collision_in > start_pause_event_in:
  - IDLE: start_pause -> RUNNING.
  - RUNNING: collision_in -> OVER. Otherwise start_pause -> PAUSED.
  - PAUSED: start_pause -> RUNNING.
  - OVER: start_pause -> IDLE, with FIFO flushed and cur_dir_out=INIT_DIR.
  - reset_event_in in any state -> IDLE, FIFO flushed, cur_dir_out=INIT_DIR, clear_pulse_out next cycle. Same-cycle start_pause, tick, collision and direction events are ignored; no drop pulse is generated.
- Direction events by state:
  - IDLE: cur_dir_out <= direction_in directly. No filtering, no FIFO.
  - RUNNING: filtered against a reference direction. The reference is the FIFO tail if count>0, else cur_dir_out. The event is dropped if it equals the reference, is opposite to it, or the FIFO is full. Otherwise it is pushed.
  - PAUSED and OVER: dropped.
  - Every dropped event gives one drop_pulse_out.
- Tick:
  - tick_in in RUNNING with no collision asserts step_pulse_out.
  - If count>0 at that edge, the FIFO head is popped into cur_dir_out in the same update.
  - Ticks in other states are ignored.
- Simultaneous push and pop: the pop takes the pre-existing head, the push appends, count is unchanged. If the FIFO is empty, a same-cycle push is not popped; it applies on the next tick.
- Pause retains FIFO contents; resume continues with them.

## Timing
- All outputs are registered.
- Event sampled at edge N -> effect visible after edge N, i.e. during cycle N+1:
  - tick -> step_pulse_out and updated cur_dir_out together, one cycle.
  - start_pause -> game_state_out.
  - reset_event_in -> clear_pulse_out, state, flush.
- step_pulse_out, clear_pulse_out and drop_pulse_out are exactly one cycle wide and never stretched.
- Collision and tick in the same cycle: OVER, no step_pulse_out.
- FIFO pointers wrap modulo QDEPTH; count saturates structurally at QDEPTH because full implies drop.
- Hardware reset mid-operation overrides everything in the same cycle.

## Test plan
- Reset, then direction 00 in IDLE -> cur_dir_out=00, state 00, count 0; start_pause -> state 01 next cycle.
- RUNNING, cur_dir=11: push 00 then 10, then two ticks -> step pulses with cur_dir 00 then 10; count goes 2, 1, 0.
- RUNNING, cur_dir=11: push 10 (reversal), then 11 (duplicate) -> two drop pulses, count stays 0. With QDEPTH=4, push 00,10,01,11 then 00 -> fifth dropped, count=4.
- Empty FIFO, cur_dir=11: push 00 in the same cycle as tick -> step with cur_dir 11, count 1; next tick -> cur_dir 00.
- RUNNING: collision and tick in the same cycle -> state 11, no step pulse. start_pause -> state 00, cur_dir=INIT_DIR, count 0.
- PAUSED with count 2: tick -> no step; reset_event_in -> clear_pulse_out one cycle, state 00, count 0, cur_dir=11.

Source files
------------

// File: rtl/snake_move_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : snake_move_scheduler_if
// Description : Event inputs and registered outputs of the snake move scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface snake_move_scheduler_if #(
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [1:0]    direction_in;
    logic          direction_valid_in;
    logic          start_pause_event_in;
    logic          reset_event_in;
    logic          tick_in;
    logic          collision_in;
    logic [1:0]    game_state_out;
    logic [1:0]    cur_dir_out;
    logic          step_pulse_out;
    logic          clear_pulse_out;
    logic          drop_pulse_out;
    logic [CW-1:0] queue_count_out;

    modport master (
        output direction_in, direction_valid_in, start_pause_event_in,
               reset_event_in, tick_in, collision_in,
        input  game_state_out, cur_dir_out, step_pulse_out,
               clear_pulse_out, drop_pulse_out, queue_count_out
    );

    modport slave (
        input  direction_in, direction_valid_in, start_pause_event_in,
               reset_event_in, tick_in, collision_in,
        output game_state_out, cur_dir_out, step_pulse_out,
               clear_pulse_out, drop_pulse_out, queue_count_out
    );
endinterface
`default_nettype wire

// File: rtl/snake_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : snake_move_scheduler
// Description : Game-state FSM plus a direction FIFO that releases at most one
//               turn per game tick.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_move_scheduler #(
    parameter int         QDEPTH   = 4,
    parameter logic [1:0] INIT_DIR = 2'b11
) (
    input  wire logic            clk,
    input  wire logic            reset,
    snake_move_scheduler_if.slave bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;
    localparam logic [1:0] ST_OVER    = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [1:0]    cur_dir_q, cur_dir_d;
    logic [1:0]    fifo_q [QDEPTH];
    logic [1:0]    fifo_d [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          step_q, step_d;
    logic          clear_q, clear_d;
    logic          drop_q, drop_d;

    logic          running;
    logic          fifo_empty;
    logic          fifo_full;
    logic [PW-1:0] tail_idx;
    logic [1:0]    ref_dir;
    logic          is_reverse;
    logic          accept;
    logic          do_step;
    logic          do_pop;
    logic          do_push;
    logic          do_drop;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.reset_event_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (bus.start_pause_event_in) state_d = ST_RUNNING;
                ST_RUNNING: begin
                    if (bus.collision_in)              state_d = ST_OVER;
                    else if (bus.start_pause_event_in) state_d = ST_PAUSED;
                end
                ST_PAUSED:  if (bus.start_pause_event_in) state_d = ST_RUNNING;
                ST_OVER:    if (bus.start_pause_event_in) state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        bus.game_state_out  = state_q;
        bus.cur_dir_out     = cur_dir_q;
        bus.step_pulse_out  = step_q;
        bus.clear_pulse_out = clear_q;
        bus.drop_pulse_out  = drop_q;
        bus.queue_count_out = count_q;
    end

    // New presses are filtered against the last queued turn, not the current heading.
    always_comb begin
        running    = (state_q == ST_RUNNING);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_COUNT);
        tail_idx   = wr_ptr_q - PW'(1);
        ref_dir    = fifo_empty ? cur_dir_q : fifo_q[tail_idx];
        is_reverse = (ref_dir[1] == bus.direction_in[1]) && (ref_dir[0] != bus.direction_in[0]);
        accept     = !((bus.direction_in == ref_dir) || is_reverse || fifo_full);
        do_step    = running && bus.tick_in && !bus.collision_in;
        do_pop     = do_step && !fifo_empty;
        do_push    = running && bus.direction_valid_in && accept;
        do_drop    = bus.direction_valid_in && (state_q != ST_IDLE) && !(running && accept);
    end

    always_comb begin
        cur_dir_d = cur_dir_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        step_d    = 1'b0;
        clear_d   = 1'b0;
        drop_d    = 1'b0;
        if (bus.reset_event_in) begin
            cur_dir_d = INIT_DIR;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            clear_d   = 1'b1;
        end else begin
            if ((state_q == ST_IDLE) && bus.direction_valid_in) cur_dir_d = bus.direction_in;
            if (do_pop) begin
                cur_dir_d = fifo_q[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                fifo_d[wr_ptr_q] = bus.direction_in;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            step_d = do_step;
            drop_d = do_drop;
            if ((state_q == ST_OVER) && bus.start_pause_event_in) begin
                cur_dir_d = INIT_DIR;
                wr_ptr_d  = '0;
                rd_ptr_d  = '0;
                count_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_dir_q <= INIT_DIR;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            step_q    <= 1'b0;
            clear_q   <= 1'b0;
            drop_q    <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= 2'b00;
        end else begin
            cur_dir_q <= cur_dir_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            step_q    <= step_d;
            clear_q   <= clear_d;
            drop_q    <= drop_d;
            fifo_q    <= fifo_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_snake_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_move_scheduler
// Description : Directed bench for snake_move_scheduler with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_move_scheduler;
    localparam int         QD   = 4;
    localparam logic [1:0] INIT = 2'b11;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    snake_move_scheduler_if #(.QDEPTH(QD)) bus ();

    snake_move_scheduler #(.QDEPTH(QD), .INIT_DIR(INIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: game state as a small integer, pending turns as a queue.
    bit         m_valid = 0;
    logic [1:0] m_state = 0;
    logic [1:0] m_dir   = INIT;
    logic [1:0] m_q[$];
    bit         m_step, m_clear, m_drop;

    always @(posedge clk) begin
        logic [1:0] s;
        logic [1:0] ref_d;
        bit         pushit;
        s      = m_state;
        pushit = 0;
        m_step = 0; m_clear = 0; m_drop = 0;
        if (reset) begin
            m_valid = 1; m_state = 0; m_dir = INIT; m_q.delete();
        end else if (bus.reset_event_in) begin
            m_state = 0; m_dir = INIT; m_q.delete(); m_clear = 1;
        end else begin
            if (bus.direction_valid_in) begin
                if (s == 0) m_dir = bus.direction_in;
                else if (s == 1) begin
                    ref_d = (m_q.size() > 0) ? m_q[$] : m_dir;
                    if (bus.direction_in == ref_d || bus.direction_in == (ref_d ^ 2'b01) || m_q.size() == QD)
                        m_drop = 1;
                    else
                        pushit = 1;
                end else m_drop = 1;
            end
            if (s == 1 && bus.tick_in && !bus.collision_in) begin
                m_step = 1;
                if (m_q.size() > 0) m_dir = m_q.pop_front();
            end
            if (pushit) m_q.push_back(bus.direction_in);
            case (s)
                0: if (bus.start_pause_event_in) m_state = 1;
                1: if (bus.collision_in) m_state = 3;
                   else if (bus.start_pause_event_in) m_state = 2;
                2: if (bus.start_pause_event_in) m_state = 1;
                default: if (bus.start_pause_event_in) begin
                    m_state = 0; m_dir = INIT; m_q.delete();
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_state", 8'(bus.game_state_out), 8'(m_state));
            chk("model_dir",   8'(bus.cur_dir_out),    8'(m_dir));
            chk("model_count", 8'(bus.queue_count_out), 8'(m_q.size()));
            chk("model_step",  8'(bus.step_pulse_out),  8'(m_step));
            chk("model_clear", 8'(bus.clear_pulse_out), 8'(m_clear));
            chk("model_drop",  8'(bus.drop_pulse_out),  8'(m_drop));
        end
    end

    // Drive one cycle of inputs from a negedge, return at the following negedge.
    task automatic drv(input bit dv, input logic [1:0] d, input bit sp, input bit re,
                       input bit tk, input bit col, input bit rs);
        bus.direction_valid_in   = dv;
        bus.direction_in         = d;
        bus.start_pause_event_in = sp;
        bus.reset_event_in       = re;
        bus.tick_in              = tk;
        bus.collision_in         = col;
        reset                    = rs;
        @(negedge clk);
        bus.direction_valid_in   = 0;
        bus.direction_in         = 0;
        bus.start_pause_event_in = 0;
        bus.reset_event_in       = 0;
        bus.tick_in              = 0;
        bus.collision_in         = 0;
        reset                    = 0;
    endtask

    task automatic push(input logic [1:0] d); drv(1, d, 0, 0, 0, 0, 0); endtask
    task automatic tick();                    drv(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic sp();                      drv(0, 0, 1, 0, 0, 0, 0); endtask
    task automatic idle();                    drv(0, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        bus.direction_valid_in = 0; bus.direction_in = 0; bus.start_pause_event_in = 0;
        bus.reset_event_in = 0; bus.tick_in = 0; bus.collision_in = 0;
        @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 1);
        chk("rst_state", 8'(bus.game_state_out), 8'd0);
        chk("rst_dir",   8'(bus.cur_dir_out),    8'd3);
        chk("rst_count", 8'(bus.queue_count_out), 8'd0);
        chk("rst_pulses", 8'({bus.step_pulse_out, bus.clear_pulse_out, bus.drop_pulse_out}), 8'd0);

        push(2'b00);
        chk("idle_dir", 8'(bus.cur_dir_out), 8'd0);
        chk("idle_nodrop", 8'(bus.drop_pulse_out), 8'd0);
        tick();
        chk("idle_tick_nostep", 8'(bus.step_pulse_out), 8'd0);
        push(2'b11);
        sp();
        chk("start_state", 8'(bus.game_state_out), 8'd1);

        push(2'b00); chk("q_cnt1", 8'(bus.queue_count_out), 8'd1);
        push(2'b10); chk("q_cnt2", 8'(bus.queue_count_out), 8'd2);
        tick();
        chk("tick1_step", 8'(bus.step_pulse_out), 8'd1);
        chk("tick1_dir",  8'(bus.cur_dir_out),    8'd0);
        chk("tick1_cnt",  8'(bus.queue_count_out), 8'd1);
        idle();
        chk("step_one_cycle", 8'(bus.step_pulse_out), 8'd0);
        tick();
        chk("tick2_dir", 8'(bus.cur_dir_out),    8'd2);
        chk("tick2_cnt", 8'(bus.queue_count_out), 8'd0);

        push(2'b00); tick(); push(2'b11); tick();
        chk("back_to_right", 8'(bus.cur_dir_out), 8'd3);
        push(2'b10);
        chk("reverse_drop", 8'(bus.drop_pulse_out), 8'd1);
        push(2'b11);
        chk("dup_drop", 8'(bus.drop_pulse_out), 8'd1);
        chk("drop_cnt0", 8'(bus.queue_count_out), 8'd0);
        push(2'b00); push(2'b10); push(2'b01); push(2'b11);
        chk("full_cnt", 8'(bus.queue_count_out), 8'd4);
        chk("full_nodrop", 8'(bus.drop_pulse_out), 8'd0);
        push(2'b00);
        chk("overflow_drop", 8'(bus.drop_pulse_out), 8'd1);
        chk("overflow_cnt",  8'(bus.queue_count_out), 8'd4);
        tick(); tick(); tick();
        chk("drain3_dir", 8'(bus.cur_dir_out), 8'd1);
        tick();
        chk("drain4_dir", 8'(bus.cur_dir_out), 8'd3);
        chk("drain_cnt",  8'(bus.queue_count_out), 8'd0);

        drv(1, 2'b00, 0, 0, 1, 0, 0);
        chk("pushpop_step", 8'(bus.step_pulse_out), 8'd1);
        chk("pushpop_dir",  8'(bus.cur_dir_out),    8'd3);
        chk("pushpop_cnt",  8'(bus.queue_count_out), 8'd1);
        tick();
        chk("pushpop_next_dir", 8'(bus.cur_dir_out), 8'd0);

        drv(0, 0, 0, 0, 1, 1, 0);
        chk("col_state",  8'(bus.game_state_out), 8'd3);
        chk("col_nostep", 8'(bus.step_pulse_out), 8'd0);
        push(2'b10);
        chk("over_drop", 8'(bus.drop_pulse_out), 8'd1);
        sp();
        chk("over_idle_state", 8'(bus.game_state_out), 8'd0);
        chk("over_idle_dir",   8'(bus.cur_dir_out),    8'd3);
        chk("over_idle_cnt",   8'(bus.queue_count_out), 8'd0);

        sp(); push(2'b00); push(2'b10); sp();
        chk("paused_state", 8'(bus.game_state_out), 8'd2);
        tick();
        chk("paused_nostep", 8'(bus.step_pulse_out), 8'd0);
        chk("paused_cnt",    8'(bus.queue_count_out), 8'd2);
        push(2'b01);
        chk("paused_drop", 8'(bus.drop_pulse_out), 8'd1);
        drv(1, 2'b01, 1, 1, 1, 0, 0);
        chk("soft_clear", 8'(bus.clear_pulse_out), 8'd1);
        chk("soft_state", 8'(bus.game_state_out), 8'd0);
        chk("soft_cnt",   8'(bus.queue_count_out), 8'd0);
        chk("soft_dir",   8'(bus.cur_dir_out),    8'd3);
        chk("soft_nodrop", 8'(bus.drop_pulse_out), 8'd0);
        idle();
        chk("clear_one_cycle", 8'(bus.clear_pulse_out), 8'd0);

        sp(); push(2'b00); sp(); sp(); tick();
        chk("resume_dir", 8'(bus.cur_dir_out), 8'd0);
        push(2'b10); push(2'b01);
        drv(1, 2'b11, 1, 0, 1, 0, 1);
        chk("hw_rst_state", 8'(bus.game_state_out), 8'd0);
        chk("hw_rst_cnt",   8'(bus.queue_count_out), 8'd0);
        chk("hw_rst_dir",   8'(bus.cur_dir_out),    8'd3);
        idle(); idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
